// File: rtl/multicycle_control.sv
// Multicycle control unit for a small LEGv8-style core. It sequences
// IF/ID/EX/MEM/WB, decodes the opcode once in ID and keeps that decode for the
// rest of the instruction. It halts with a sticky fault on an illegal opcode
// or when a memory stalls too long.
`timescale 1ns/1ps
module multicycle_control #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pcsrc,
    output logic        reg2loc,
    output logic        alusrc,
    output logic        mem2reg,
    output logic        regwrite,
    output logic        memread,
    output logic        memwrite,
    output logic [3:0]  aluop,
    output logic [2:0]  signop,
    output logic [2:0]  state,
    output logic        fault,
    output logic [31:0] retired
);
    localparam int unsigned CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    // Stall count at which one more low ready cycle brings the counter to WAIT_MAX.
    localparam logic [CW-1:0] LAST_STALL = CW'(WAIT_MAX - 1);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_LDUR, C_STUR, C_ADDREG, C_ADDIMM, C_SUBREG, C_SUBIMM,
        C_ANDREG, C_ORRREG, C_CBZ, C_B, C_MOVZ, C_ILLEGAL
    } cls_t;

    state_t        state_q, state_d;
    cls_t          dec_cls, cls_q, cur_cls;
    logic [1:0]    hw_q, cur_hw;
    logic [CW-1:0] wait_q, wait_d;
    logic          fault_q;
    logic [31:0]   retired_q;

    assign state   = state_q;
    assign fault   = fault_q;
    assign retired = retired_q;

    // Opcode classification; the first matching pattern wins.
    always_comb begin
        if      (opcode ==? 11'b??111000010) dec_cls = C_LDUR;
        else if (opcode ==? 11'b??111000000) dec_cls = C_STUR;
        else if (opcode ==? 11'b?0?01011???) dec_cls = C_ADDREG;
        else if (opcode ==? 11'b?0?10001???) dec_cls = C_ADDIMM;
        else if (opcode ==? 11'b?1?01011???) dec_cls = C_SUBREG;
        else if (opcode ==? 11'b?1?10001???) dec_cls = C_SUBIMM;
        else if (opcode ==? 11'b?0001010???) dec_cls = C_ANDREG;
        else if (opcode ==? 11'b?0101010???) dec_cls = C_ORRREG;
        else if (opcode ==? 11'b?011010????) dec_cls = C_CBZ;
        else if (opcode ==? 11'b?00101?????) dec_cls = C_B;
        else if (opcode ==? 11'b110100101??) dec_cls = C_MOVZ;
        else                                 dec_cls = C_ILLEGAL;
    end

    // Next-state, wait counter and every control output for the current state.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
        state_d  = state_q;
        wait_d   = '0;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        pcsrc    = 1'b0;
        reg2loc  = 1'b0;
        alusrc   = 1'b0;
        mem2reg  = 1'b0;
        regwrite = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        aluop    = 4'b0000;
        signop   = 3'b000;
        // ID decodes live; later states replay the class captured on leaving ID.
        cur_cls  = (state_q == S_ID) ? dec_cls : cls_q;
        cur_hw   = (state_q == S_ID) ? opcode[1:0] : hw_q;

        // While resetl is low the state register already reads IF, but nothing may be requested.
        if (resetl) begin
            if (state_q inside {S_ID, S_EX, S_MEM, S_WB}) begin
                case (cur_cls)
                    C_LDUR:   begin aluop = 4'b0010; alusrc = 1'b1; mem2reg = 1'b1; end
                    C_STUR:   begin aluop = 4'b0010; alusrc = 1'b1; reg2loc = 1'b1; end
                    C_ADDREG: aluop = 4'b0010;
                    C_ADDIMM: begin aluop = 4'b0010; signop = 3'b001; alusrc = 1'b1; end
                    C_SUBREG: aluop = 4'b0110;
                    C_SUBIMM: begin aluop = 4'b0110; signop = 3'b001; alusrc = 1'b1; end
                    C_ANDREG: aluop = 4'b0000;
                    C_ORRREG: aluop = 4'b0001;
                    C_CBZ:    begin aluop = 4'b0111; signop = 3'b010; reg2loc = 1'b1; end
                    C_B:      signop = 3'b011;
                    C_MOVZ:   begin aluop = 4'b0111; signop = {1'b1, cur_hw}; alusrc = 1'b1; end
                    default:  ;
                endcase
            end

            case (state_q)
                S_IF: begin
                    imem_req = 1'b1;
                    memread  = 1'b1;
                    if (imem_ready) begin
                        ir_write = 1'b1;
                        state_d  = S_ID;
                    end else if (wait_q == LAST_STALL) begin
                        state_d = S_HALT;
                    end else begin
                        wait_d = wait_q + CW'(1);
                    end
                end
                S_ID: state_d = (dec_cls == C_ILLEGAL) ? S_HALT : S_EX;
                S_EX: begin
                    case (cur_cls)
                        C_B:            begin pc_write = 1'b1; pcsrc = 1'b1; state_d = S_IF; end
                        C_CBZ:          begin pc_write = 1'b1; pcsrc = zero; state_d = S_IF; end
                        C_LDUR, C_STUR: state_d = S_MEM;
                        default:        state_d = S_WB;
                    endcase
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    memread  = (cur_cls == C_LDUR);
                    memwrite = (cur_cls == C_STUR);
                    if (dmem_ready) begin
                        if (cur_cls == C_LDUR) begin
                            state_d = S_WB;
                        end else begin
                            pc_write = 1'b1;
                            state_d  = S_IF;
                        end
                    end else if (wait_q == LAST_STALL) begin
                        state_d = S_HALT;
                    end else begin
                        wait_d = wait_q + CW'(1);
                    end
                end
                S_WB: begin
                    regwrite = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_IF;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // State, captured decode, wait counter, sticky fault and retire counter.
    always_ff @(posedge CLK or negedge resetl) begin
        // NOTE: every flop here is reset, including the captured decode, so no X can reach the controls.
        if (!resetl) begin
            state_q   <= S_IF;
            cls_q     <= C_ILLEGAL;
            hw_q      <= 2'b00;
            wait_q    <= '0;
            fault_q   <= 1'b0;
            retired_q <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments keep each flop reading pre-edge values of the others.
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == S_ID) begin
                cls_q <= dec_cls;
                hw_q  <= opcode[1:0];
            end
            if (state_d == S_HALT) fault_q <= 1'b1;
            retired_q <= retired_q + 32'(pc_write);
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a decode table, hand-written
// corner-case sequences, and random traffic against a route-based reference.
`timescale 1ns/1ps
module tb_multicycle_control;
    localparam int WAIT_MAX = 15;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] OP_ILL  = 11'b00000000000;

    logic        CLK = 1'b0;
    logic        resetl = 1'b0;
    logic [10:0] opcode = '0;
    logic        zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic        imem_req, dmem_req, ir_write, pc_write, pcsrc, reg2loc, alusrc;
    logic        mem2reg, regwrite, memread, memwrite, fault;
    logic [3:0]  aluop;
    logic [2:0]  signop, state;
    logic [31:0] retired;

    always #5 CLK = ~CLK;

    multicycle_control #(.WAIT_MAX(WAIT_MAX)) dut (
        .CLK(CLK), .resetl(resetl), .opcode(opcode), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .ir_write(ir_write),
        .pc_write(pc_write), .pcsrc(pcsrc), .reg2loc(reg2loc), .alusrc(alusrc),
        .mem2reg(mem2reg), .regwrite(regwrite), .memread(memread),
        .memwrite(memwrite), .aluop(aluop), .signop(signop), .state(state),
        .fault(fault), .retired(retired)
    );

    typedef struct packed {
        logic [31:0] retired;
        logic [2:0]  state;
        logic        fault;
        logic [3:0]  aluop;
        logic [2:0]  signop;
        logic        imem_req, dmem_req, ir_write, pc_write, pcsrc, reg2loc;
        logic        alusrc, mem2reg, regwrite, memread, memwrite;
    } outs_t;

    outs_t dut_o;
    assign dut_o = {retired, state, fault, aluop, signop, imem_req, dmem_req,
                    ir_write, pc_write, pcsrc, reg2loc, alusrc, mem2reg,
                    regwrite, memread, memwrite};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {
        K_LDUR, K_STUR, K_ADDREG, K_ADDIMM, K_SUBREG, K_SUBIMM,
        K_ANDREG, K_ORRREG, K_CBZ, K_B, K_MOVZ, K_ILLEGAL
    } kind_t;

    // Opcode patterns, MSB (bit 10) first, in priority order.
    string pat [11] = '{"??111000010", "??111000000", "?0?01011???", "?0?10001???",
                        "?1?01011???", "?1?10001???", "?0001010???", "?0101010???",
                        "?011010????", "?00101?????", "110100101??"};

    int          m_phase;   // 0=IF 1=ID 2=EX 3=MEM 4=WB 7=HALT
    kind_t       m_kind;
    logic [1:0]  m_hw;
    int          m_route[$];
    int          m_stall;
    bit          m_fault;
    logic [31:0] m_retired;

    function automatic kind_t classify(input logic [10:0] op);
        string p;
        bit    ok;
        for (int k = 0; k < 11; k++) begin
            p  = pat[k];
            ok = 1'b1;
            for (int i = 0; i < 11; i++)
                if (p[i] != "?" && op[10-i] != (p[i] == "1")) ok = 1'b0;
            if (ok) return kind_t'(k);
        end
        return K_ILLEGAL;
    endfunction

    function automatic logic [10:0] gen_opcode();
        logic [10:0] op;
        string       p;
        if ($urandom_range(0, 11) == 0) return 11'($urandom);
        p = pat[$urandom_range(0, 10)];
        for (int i = 0; i < 11; i++)
            op[10-i] = (p[i] == "?") ? 1'($urandom) : (p[i] == "1");
        return op;
    endfunction

    function automatic outs_t class_ctl(input kind_t k, input logic [1:0] hw);
        outs_t o;
        o = '0;
        case (k)
            K_LDUR:   begin o.aluop = 4'b0010; o.alusrc = 1'b1; o.mem2reg = 1'b1; end
            K_STUR:   begin o.aluop = 4'b0010; o.alusrc = 1'b1; o.reg2loc = 1'b1; end
            K_ADDREG: o.aluop = 4'b0010;
            K_ADDIMM: begin o.aluop = 4'b0010; o.signop = 3'b001; o.alusrc = 1'b1; end
            K_SUBREG: o.aluop = 4'b0110;
            K_SUBIMM: begin o.aluop = 4'b0110; o.signop = 3'b001; o.alusrc = 1'b1; end
            K_ANDREG: o.aluop = 4'b0000;
            K_ORRREG: o.aluop = 4'b0001;
            K_CBZ:    begin o.aluop = 4'b0111; o.signop = 3'b010; o.reg2loc = 1'b1; end
            K_B:      o.signop = 3'b011;
            K_MOVZ:   begin o.aluop = 4'b0111; o.signop = {1'b1, hw}; o.alusrc = 1'b1; end
            default:  ;
        endcase
        return o;
    endfunction

    function automatic outs_t model_outs();
        outs_t      o;
        kind_t      k;
        logic [1:0] hw;
        k  = (m_phase == 1) ? classify(opcode) : m_kind;
        hw = (m_phase == 1) ? opcode[1:0] : m_hw;
        o  = '0;
        if (m_phase >= 1 && m_phase <= 4) o = class_ctl(k, hw);
        case (m_phase)
            0: begin o.imem_req = 1'b1; o.memread = 1'b1; o.ir_write = imem_ready; end
            2: if (k == K_B) begin o.pc_write = 1'b1; o.pcsrc = 1'b1; end
               else if (k == K_CBZ) begin o.pc_write = 1'b1; o.pcsrc = zero; end
            3: begin
                o.dmem_req = 1'b1;
                o.memread  = (k == K_LDUR);
                o.memwrite = (k == K_STUR);
                o.pc_write = (k == K_STUR) && dmem_ready;
            end
            4: begin o.regwrite = 1'b1; o.pc_write = 1'b1; end
            default: ;
        endcase
        o.state   = 3'(m_phase);
        o.fault   = m_fault;
        o.retired = m_retired;
        return o;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_kind = K_ILLEGAL; m_hw = 2'b00; m_route.delete();
        m_stall = 0; m_fault = 1'b0; m_retired = 32'd0;
    endtask

    task automatic advance();
        if (m_route.size() == 0) m_phase = 0;
        else m_phase = m_route.pop_front();
        if (m_phase == 0 || m_phase == 3) m_stall = 0;
    endtask

    task automatic model_step();
        outs_t o;
        kind_t k;
        bit    rdy;
        o = model_outs();
        m_retired = m_retired + 32'(o.pc_write);
        case (m_phase)
            0, 3: begin
                rdy = (m_phase == 0) ? imem_ready : dmem_ready;
                if (rdy) begin
                    if (m_phase == 0) begin m_phase = 1; m_stall = 0; end
                    else advance();
                end else begin
                    m_stall++;
                    if (m_stall == WAIT_MAX) begin m_phase = 7; m_fault = 1'b1; end
                end
            end
            1: begin
                k = classify(opcode);
                if (k == K_ILLEGAL) begin
                    m_phase = 7; m_fault = 1'b1;
                end else begin
                    m_kind = k; m_hw = opcode[1:0];
                    m_route.delete();
                    m_route.push_back(2);
                    case (k)
                        K_LDUR:     begin m_route.push_back(3); m_route.push_back(4); end
                        K_STUR:     m_route.push_back(3);
                        K_B, K_CBZ: ;
                        default:    m_route.push_back(4);
                    endcase
                    m_phase = m_route.pop_front();
                end
            end
            2, 4: advance();
            default: ;
        endcase
    endtask

    // ---------------- stimulus helpers (inputs change at posedge+1) ----------------
    task automatic drive(input logic [10:0] op, input logic ir, input logic dr, input logic z);
        opcode = op; imem_ready = ir; dmem_ready = dr; zero = z;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic step_checked(input string name);
        settle();
        check(name, 64'(dut_o), 64'(model_outs()));
        tick();
    endtask

    task automatic do_reset();
        resetl = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0; zero = 1'b0;
        model_reset();
        settle();
        check("reset_outputs", 64'(dut_o), 64'd0);
        @(posedge CLK);
        #1;
        resetl = 1'b1;
    endtask

    // ---------------- decode table ----------------
    typedef struct {
        logic [10:0] op;
        logic [8:0]  ctl;    // {aluop, signop, alusrc, reg2loc, mem2reg}
        bit          legal;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [10:0] op, input logic [8:0] ctl, input bit legal, input string name);
        vec_t v;
        v.op = op; v.ctl = ctl; v.legal = legal; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic test_decode_table();
        add_vec(11'b11111000010, 9'b0010_000_1_0_1, 1'b1, "dec_ldur");
        add_vec(11'b11111000000, 9'b0010_000_1_1_0, 1'b1, "dec_stur");
        add_vec(11'b10001011000, 9'b0010_000_0_0_0, 1'b1, "dec_addreg");
        add_vec(11'b10010001000, 9'b0010_001_1_0_0, 1'b1, "dec_addimm");
        add_vec(11'b11001011000, 9'b0110_000_0_0_0, 1'b1, "dec_subreg");
        add_vec(11'b11010001000, 9'b0110_001_1_0_0, 1'b1, "dec_subimm");
        add_vec(11'b10001010000, 9'b0000_000_0_0_0, 1'b1, "dec_andreg");
        add_vec(11'b10101010000, 9'b0001_000_0_0_0, 1'b1, "dec_orrreg");
        add_vec(11'b10110100000, 9'b0111_010_0_1_0, 1'b1, "dec_cbz");
        add_vec(11'b00010100000, 9'b0000_011_0_0_0, 1'b1, "dec_b");
        add_vec(11'b10010111111, 9'b0000_011_0_0_0, 1'b1, "dec_b_wild");
        add_vec(11'b11010010101, 9'b0111_101_1_0_0, 1'b1, "dec_movz_hw1");
        add_vec(11'b11010010111, 9'b0111_111_1_0_0, 1'b1, "dec_movz_hw3");
        add_vec(11'b00000000000, 9'b0000_000_0_0_0, 1'b0, "dec_illegal");
        foreach (vecs[i]) begin
            do_reset();
            drive(vecs[i].op, 1'b1, 1'b0, 1'b0);
            step_checked({vecs[i].name, "_if"});
            settle();
            check({vecs[i].name, "_id_ctl"}, 64'({aluop, signop, alusrc, reg2loc, mem2reg}), 64'(vecs[i].ctl));
            check({vecs[i].name, "_id_state"}, 64'(state), 64'd1);
            tick();
            settle();
            check({vecs[i].name, "_next_state"}, 64'(state), vecs[i].legal ? 64'd2 : 64'd7);
            check({vecs[i].name, "_held_ctl"}, 64'({aluop, signop, alusrc, reg2loc, mem2reg}), 64'(vecs[i].ctl));
        end
    endtask

    // ---------------- hand-written sequences ----------------
    task automatic test_addreg();
        int add_states[4] = '{0, 1, 2, 4};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(OP_ADD, 1'b1, 1'b1, 1'b0);
            settle();
            check("add_state", 64'(state), 64'(add_states[i]));
            check("add_regwrite", 64'(regwrite), (i == 3) ? 64'd1 : 64'd0);
            if (i > 0) check("add_aluop", 64'(aluop), 64'b0010);
            check("add_model", 64'(dut_o), 64'(model_outs()));
            tick();
        end
        settle();
        check("add_back_to_if", 64'(state), 64'd0);
        check("add_retired", 64'(retired), 64'd1);
    endtask

    task automatic test_ldur();
        do_reset();
        drive(OP_LDUR, 1'b1, 1'b0, 1'b0);
        step_checked("ldur_if");
        step_checked("ldur_id");
        step_checked("ldur_ex");
        for (int i = 0; i < 4; i++) begin
            drive(OP_LDUR, 1'b0, (i == 3), 1'b0);
            settle();
            check("ldur_mem_state", 64'(state), 64'd3);
            check("ldur_memread", 64'(memread), 64'd1);
            check("ldur_dmem_req", 64'(dmem_req), 64'd1);
            tick();
        end
        drive(OP_LDUR, 1'b0, 1'b0, 1'b0);
        settle();
        check("ldur_wb_state", 64'(state), 64'd4);
        check("ldur_mem2reg", 64'(mem2reg), 64'd1);
        check("ldur_regwrite", 64'(regwrite), 64'd1);
        tick();
        settle();
        check("ldur_retired", 64'(retired), 64'd1);
        check("ldur_back_to_if", 64'(state), 64'd0);
    endtask

    task automatic test_cbz(input logic z);
        do_reset();
        drive(OP_CBZ, 1'b1, 1'b1, z);
        step_checked("cbz_if");
        step_checked("cbz_id");
        settle();
        check("cbz_ex_state", 64'(state), 64'd2);
        check("cbz_pc_write", 64'(pc_write), 64'd1);
        check("cbz_pcsrc", 64'(pcsrc), 64'(z));
        tick();
        settle();
        check("cbz_skips_wb", 64'(state), 64'd0);
        check("cbz_retired", 64'(retired), 64'd1);
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < WAIT_MAX; i++) begin
            drive(OP_ADD, 1'b0, 1'b0, 1'b0);
            settle();
            check("stall_state", 64'(state), 64'd0);
            check("stall_fault", 64'(fault), 64'd0);
            tick();
        end
        settle();
        check("stall_halt_state", 64'(state), 64'd7);
        check("stall_fault_set", 64'(fault), 64'd1);
        check("stall_halt_model", 64'(dut_o), 64'(model_outs()));
        do_reset();
        for (int i = 0; i < WAIT_MAX; i++) begin
            drive(OP_ADD, (i == WAIT_MAX - 1), 1'b0, 1'b0);
            step_checked("late_ready");
        end
        settle();
        check("late_ready_state", 64'(state), 64'd1);
        check("late_ready_fault", 64'(fault), 64'd0);
    endtask

    task automatic test_illegal_and_midmem_reset();
        do_reset();
        drive(OP_ILL, 1'b1, 1'b0, 1'b0);
        step_checked("ill_if");
        drive(OP_ILL, 1'b0, 1'b0, 1'b0);
        step_checked("ill_id");
        for (int i = 0; i < 3; i++) begin
            drive(OP_ILL, 1'b1, 1'b1, 1'b0);
            settle();
            check("halt_state", 64'(state), 64'd7);
            check("halt_fault", 64'(fault), 64'd1);
            check("halt_ignores_ready", 64'({imem_req, ir_write, dmem_req, pc_write}), 64'd0);
            tick();
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(OP_ADD, 1'b1, 1'b1, 1'b0);
            step_checked("pre_mem_add");
        end
        drive(OP_LDUR, 1'b1, 1'b0, 1'b0);
        step_checked("mm_if");
        step_checked("mm_id");
        step_checked("mm_ex");
        drive(OP_LDUR, 1'b0, 1'b0, 1'b0);
        step_checked("mm_mem0");
        settle();
        check("mm_in_mem", 64'(state), 64'd3);
        check("mm_retired_before", 64'(retired), 64'd1);
        resetl = 1'b0;
        #1;
        check("mm_reset_state", 64'(state), 64'd0);
        check("mm_reset_outputs", 64'(dut_o), 64'd0);
        @(posedge CLK);
        #1;
        resetl = 1'b1;
        model_reset();
        drive(OP_ADD, 1'b0, 1'b0, 1'b0);
        settle();
        check("after_reset_imem_req", 64'(imem_req), 64'd1);
        check("after_reset_model", 64'(dut_o), 64'(model_outs()));
        tick();
    endtask

    // ---------------- randomized traffic ----------------
    task automatic test_random();
        int          low_burst = 0;
        int          halt_cycles = 0;
        logic [10:0] op = OP_ADD;
        logic        ir, dr;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (m_phase == 7) begin
                halt_cycles++;
                if (halt_cycles > 2) begin
                    do_reset();
                    halt_cycles = 0;
                end
            end
            if (m_phase == 0) op = gen_opcode();
            if (low_burst == 0 && $urandom_range(0, 199) == 0) low_burst = WAIT_MAX + 5;
            ir = (low_burst > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
            dr = (low_burst > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (low_burst > 0) low_burst--;
            drive(op, ir, dr, 1'($urandom_range(0, 1)));
            step_checked("random_cycle");
        end
    endtask

    initial begin
        model_reset();
        @(posedge CLK);
        #1;
        test_addreg();
        test_ldur();
        test_cbz(1'b1);
        test_cbz(1'b0);
        test_stall();
        test_illegal_and_midmem_reset();
        test_decode_table();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
